// File: rtl/similarity_hf_core.sv
// Hamming-distance classifier for hyperdimensional vectors.
// A query vector is captured on a start strobe and compared chunk by chunk
// against a non-seizure and a seizure prototype. The class whose prototype is
// strictly closer wins; a tie resolves to non-seizure. The result is reported
// with a one-cycle valid pulse at a fixed latency of DIMENSIONS/CHUNK+1 edges.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for en; captures hv and clears accumulators on start
//   BUSY  | accumulates per-chunk distances, one chunk per cycle
//   DONE  | compares distances, registers label and pulses out, back to IDLE
module similarity_hf_core #(
    parameter int DIMENSIONS = 10000,
    parameter int CHUNK      = 100
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [DIMENSIONS-1:0] hv,
    input  logic [DIMENSIONS-1:0] ns_hv,
    input  logic [DIMENSIONS-1:0] s_hv,
    output logic                  out,
    output logic                  label_out
);

    localparam int NCHUNK = DIMENSIONS / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int AW     = $clog2(DIMENSIONS + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                r_state;
    logic [DIMENSIONS-1:0] r_hv;
    logic [IW-1:0]         r_idx;
    logic [AW-1:0]         r_dist_ns;
    logic [AW-1:0]         r_dist_s;
    logic                  r_out;
    logic                  r_label;

    int                    w_base;
    logic [CHUNK-1:0]      w_diff_ns;
    logic [CHUNK-1:0]      w_diff_s;
    logic [AW-1:0]         w_pop_ns;
    logic [AW-1:0]         w_pop_s;

    // A chunk popcount never exceeds CHUNK <= DIMENSIONS, so AW bits always suffice.
    function automatic logic [AW-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [AW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c = c + AW'(v[i]);
        end
        return c;
    endfunction

    // Select the current chunk and count differing bits against both prototypes.
    always_comb begin
        w_base    = int'(r_idx) * CHUNK;
        w_diff_ns = r_hv[w_base +: CHUNK] ^ ns_hv[w_base +: CHUNK];
        w_diff_s  = r_hv[w_base +: CHUNK] ^ s_hv[w_base +: CHUNK];
        w_pop_ns  = popcount(w_diff_ns);
        w_pop_s   = popcount(w_diff_s);
    end

    // Sequencer: capture, chunked accumulation, then registered decision and pulse.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            r_state   <= IDLE;
            r_hv      <= '0;
            r_idx     <= '0;
            r_dist_ns <= '0;
            r_dist_s  <= '0;
            r_out     <= 1'b0;
            r_label   <= 1'b0;
        end else begin
            r_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_hv      <= hv;
                        r_idx     <= '0;
                        r_dist_ns <= '0;
                        r_dist_s  <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    r_dist_ns <= r_dist_ns + w_pop_ns;
                    r_dist_s  <= r_dist_s + w_pop_s;
                    // Index parks on the last chunk so it never points past the vector.
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_label <= (r_dist_s < r_dist_ns);
                    r_out   <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out       = r_out;
    assign label_out = r_label;

endmodule

// File: tb/tb_similarity_hf_core.sv
module tb_similarity_hf_core;

    localparam int D   = 10000;
    localparam int C   = 100;
    localparam int LAT = D / C + 1;

    logic         clk = 1'b0;
    logic         nrst;
    logic         en;
    logic [D-1:0] hv;
    logic [D-1:0] ns_hv;
    logic [D-1:0] s_hv;
    logic         out;
    logic         label_out;

    always #5 clk = ~clk;

    similarity_hf_core #(.DIMENSIONS(D), .CHUNK(C)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .hv        (hv),
        .ns_hv     (ns_hv),
        .s_hv      (s_hv),
        .out       (out),
        .label_out (label_out)
    );

    typedef struct {
        logic  lbl;
        int    cyc;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    logic prev_out = 1'b0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every out pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (out === 1'b1) begin
            check("out_single_cycle", {31'd0, prev_out}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: got pulse at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_label"}, {31'd0, label_out}, {31'd0, mon_e.lbl});
                check({mon_e.name, "_latency"}, cyc, mon_e.cyc);
            end
        end
        prev_out = out;
    end

    function automatic logic [D-1:0] make_ones(input int n);
        logic [D-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [D-1:0] rand_vec();
        logic [D-1:0] v;
        logic [31:0]  w;
        v = '0;
        for (int i = 0; i < D; i += 32) begin
            w = $urandom;
            for (int j = 0; j < 32; j++) if (i + j < D) v[i+j] = w[j];
        end
        return v;
    endfunction

    task automatic issue(input logic [D-1:0] v, input logic lbl, input string name);
        @(negedge clk);
        hv = v;
        en = 1'b1;
        sb.push_back('{lbl, cyc + 1 + LAT, name});
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [D-1:0] v, input logic [D-1:0] ns, input logic [D-1:0] s,
                          input logic lbl, input string name);
        @(negedge clk);
        ns_hv = ns;
        s_hv  = s;
        issue(v, lbl, name);
        wait_drain(LAT + 40);
        check({name, "_hold"}, {31'd0, label_out}, {31'd0, lbl});
    endtask

    logic [D-1:0] ones;
    logic [D-1:0] v;
    logic [D-1:0] rns;
    logic [D-1:0] rs;
    logic         lbl;
    int           base;

    initial begin
        ones  = '1;
        nrst  = 1'b1;
        en    = 1'b0;
        hv    = '0;
        ns_hv = '0;
        s_hv  = '0;
        #1;
        check("reset_out", {31'd0, out}, 32'd0);
        check("reset_label", {31'd0, label_out}, 32'd0);
        repeat (3) @(negedge clk);

        // en on the very first edge after reset release; hv=1 -> dist_ns=1, dist_s=9999
        nrst  = 1'b0;
        ns_hv = '0;
        s_hv  = ones;
        hv    = make_ones(1);
        en    = 1'b1;
        sb.push_back('{1'b0, cyc + 1 + LAT, "first_after_reset"});
        @(negedge clk);
        en = 1'b0;
        wait_drain(LAT + 40);

        run_op(ones, '0, ones, 1'b1, "all_ones");
        run_op(make_ones(5000), '0, ones, 1'b0, "tie_5000");
        run_op(make_ones(5001), '0, ones, 1'b1, "ones_5001");
        run_op('0, ones, '0, 1'b1, "swapped_protos");
        run_op('0, '0, ones, 1'b0, "zero_query");
        v = '0;
        v[D-1] = 1'b1;
        run_op(v, v, '0, 1'b0, "top_bit");

        // en during BUSY is ignored, and hv changes after capture have no effect
        @(negedge clk);
        ns_hv = '0;
        s_hv  = ones;
        issue(ones, 1'b1, "busy_en_ignored");
        repeat (10) @(negedge clk);
        hv = '0;
        en = 1'b1;
        repeat (20) @(negedge clk);
        en = 1'b0;
        wait_drain(LAT + 40);

        // en held high: one capture per IDLE visit, spaced LAT+1 edges
        @(negedge clk);
        hv   = ones;
        en   = 1'b1;
        base = cyc;
        for (int k = 0; k < 3; k++) sb.push_back('{1'b1, base + 1 + k * (LAT + 1) + LAT, "en_held"});
        repeat (300) @(negedge clk);
        en = 1'b0;
        wait_drain(LAT + 40);

        // Reset at BUSY cycle ~50: immediate clear, no pulse, then normal operation
        run_op(ones, '0, ones, 1'b1, "pre_abort");
        issue(make_ones(1), 1'b0, "aborted");
        repeat (49) @(negedge clk);
        nrst = 1'b1;
        void'(sb.pop_back());
        #1;
        check("abort_out", {31'd0, out}, 32'd0);
        check("abort_label", {31'd0, label_out}, 32'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        repeat (LAT + 20) @(negedge clk);
        run_op(ones, '0, ones, 1'b1, "post_abort");

        // Random vectors against a popcount reference
        for (int k = 0; k < 150; k++) begin
            v   = rand_vec();
            rns = rand_vec();
            rs  = rand_vec();
            lbl = ($countones(v ^ rs) < $countones(v ^ rns));
            run_op(v, rns, rs, lbl, "random");
        end

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
